// File: rtl/falafel_pkg.sv
// falafel_pkg: shared types and widths for the falafel request front end.
//   DATA_W      width of one request beat from the core
//   REQ_W       width of one request word pushed into the request FIFO
//   in_state_e  states of the request-pairing FSM
//   req_pair_t  request word layout, beat0 in the low half
package falafel_pkg;

  localparam int DATA_W = 8;
  localparam int REQ_W  = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_BEAT0,
    S_BEAT1,
    S_PUSH
  } in_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] beat1;
    logic [DATA_W-1:0] beat0;
  } req_pair_t;

endpackage

// File: rtl/falafel_beat_timer.sv
// falafel_beat_timer: clear/enable/expire counter that bounds the wait
// between the two beats of a request.
//   clk_i     clock
//   rst_ni    async active-low reset, counter returns to 0
//   clear_i   force the count to 0 (has priority over enable)
//   en_i      count one idle cycle
//   expire_o  count has reached TIMEOUT_CYCLES
module falafel_beat_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_reg;

  assign expire_o = (count_reg == LIMIT);

  // Saturates at the limit so a held enable can never wrap back below it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= '0;
    end else if (clear_i) begin
      count_reg <= '0;
    end else if (en_i && !expire_o) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/falafel_input_fsm.sv
// falafel_input_fsm: request-side front end of falafel. Accepts beats from
// the core over val/rdy, pairs beat0 (header) and beat1 (address) into one
// request word and pushes it into the request FIFO feeding the allocator.
//   clk_i             clock
//   rst_ni            async active-low reset
//   req_val_i         core presents a request beat
//   req_rdy_o         block accepts a beat this cycle
//   req_data_i        request beat
//   req_fifo_full_i   request FIFO full
//   req_fifo_write_o  push strobe into the request FIFO
//   req_fifo_din_o    {beat1, beat0}, beat0 in the low half
//   err_o             one-cycle pulse when a partial request is dropped
// Build option: define FALAFEL_INPUT_TIMEOUT_EN to give up on a lone beat0
// after TIMEOUT_CYCLES idle cycles in S_BEAT1; otherwise S_BEAT1 waits
// forever and err_o is constant 0.
module falafel_input_fsm
  import falafel_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_val_i,
  output logic              req_rdy_o,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic              req_fifo_full_i,
  output logic              req_fifo_write_o,
  output logic [REQ_W-1:0]  req_fifo_din_o,
  output logic              err_o
);

  in_state_e   state_reg, state_next;
  req_pair_t   pair_reg;
  logic        cap_beat0, cap_beat1;
  logic        err_next;

`ifdef FALAFEL_INPUT_TIMEOUT_EN
  logic timer_clear, timer_en, timer_expire;

  // Clearing whenever we are outside S_BEAT1 makes every entry start at 0.
  assign timer_clear = (state_reg != S_BEAT1);

  falafel_beat_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_beat_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (timer_clear),
    .en_i     (timer_en),
    .expire_o (timer_expire)
  );

  assign err_o = err_next;
`else
  // Always false: without the timer a partial request is never dropped.
  assign err_o = (TIMEOUT_CYCLES < 0);
`endif

  // Request word comes straight from the beat registers, so it cannot move
  // while the FSM is stalled in S_PUSH.
  assign req_fifo_din_o = pair_reg;

  always_comb begin
    state_next       = state_reg;
    req_rdy_o        = 1'b0;
    req_fifo_write_o = 1'b0;
    cap_beat0        = 1'b0;
    cap_beat1        = 1'b0;
    err_next         = 1'b0;
`ifdef FALAFEL_INPUT_TIMEOUT_EN
    timer_en         = 1'b0;
`endif
    case (state_reg)
      S_BEAT0: begin
        req_rdy_o = 1'b1;
        if (req_val_i) begin
          cap_beat0  = 1'b1;
          state_next = S_BEAT1;
        end
      end
      S_BEAT1: begin
        req_rdy_o = 1'b1;
        if (req_val_i) begin
          // A beat arriving on the limit cycle still wins over the timeout.
          cap_beat1  = 1'b1;
          state_next = S_PUSH;
        end
`ifdef FALAFEL_INPUT_TIMEOUT_EN
        else begin
          timer_en = 1'b1;
          if (timer_expire) begin
            err_next   = 1'b1;
            state_next = S_BEAT0;
          end
        end
`endif
      end
      S_PUSH: begin
        // Ready only when the write happens, so a beat is never accepted
        // while the finished request is still waiting for FIFO space.
        if (!req_fifo_full_i) begin
          req_fifo_write_o = 1'b1;
          req_rdy_o        = 1'b1;
          if (req_val_i) begin
            cap_beat0  = 1'b1;
            state_next = S_BEAT1;
          end else begin
            state_next = S_BEAT0;
          end
        end
      end
      default: state_next = S_BEAT0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_BEAT0;
      pair_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (cap_beat0) pair_reg.beat0 <= req_data_i;
      if (cap_beat1) pair_reg.beat1 <= req_data_i;
    end
  end

endmodule

// File: tb/tb_falafel_input_fsm.sv
// tb_falafel_input_fsm: directed self-checking bench for falafel_input_fsm.
// Inputs change 1 ns after the rising edge and outputs are checked in the
// same window, before the next edge.
module tb_falafel_input_fsm;
  import falafel_pkg::*;

  logic              clk_i;
  logic              rst_ni;
  logic              req_val_i;
  logic              req_rdy_o;
  logic [DATA_W-1:0] req_data_i;
  logic              req_fifo_full_i;
  logic              req_fifo_write_o;
  logic [REQ_W-1:0]  req_fifo_din_o;
  logic              err_o;

  int checks = 0;
  int errors = 0;

  falafel_input_fsm #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_val_i        (req_val_i),
    .req_rdy_o        (req_rdy_o),
    .req_data_i       (req_data_i),
    .req_fifo_full_i  (req_fifo_full_i),
    .req_fifo_write_o (req_fifo_write_o),
    .req_fifo_din_o   (req_fifo_din_o),
    .err_o            (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [REQ_W-1:0] held;
    rst_ni          = 1'b0;
    req_val_i       = 1'b0;
    req_data_i      = '0;
    req_fifo_full_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    chk("reset_rdy", {31'd0, req_rdy_o}, 32'd1);
    chk("reset_write", {31'd0, req_fifo_write_o}, 32'd0);
    chk("reset_din", {16'd0, req_fifo_din_o}, 32'd0);
    chk("reset_err", {31'd0, err_o}, 32'd0);
    tick();

    // Single request A1, B2: written on the cycle after B2 is accepted.
    req_val_i = 1'b1; req_data_i = 8'hA1; #1;
    chk("t2_rdy_b0", {31'd0, req_rdy_o}, 32'd1);
    chk("t2_nowr_b0", {31'd0, req_fifo_write_o}, 32'd0);
    tick();
    req_data_i = 8'hB2; #1;
    chk("t2_rdy_b1", {31'd0, req_rdy_o}, 32'd1);
    chk("t2_nowr_b1", {31'd0, req_fifo_write_o}, 32'd0);
    tick();
    req_val_i = 1'b0; req_data_i = 8'h00; #1;
    chk("t2_write", {31'd0, req_fifo_write_o}, 32'd1);
    chk("t2_din", {16'd0, req_fifo_din_o}, 32'h0000B2A1);
    tick();
    chk("t2_single_write", {31'd0, req_fifo_write_o}, 32'd0);
    tick();

    // Held valid, beats 10..15: writes on cycles 2, 4, 6 with pairs in order.
    for (int c = 0; c < 7; c++) begin
      req_val_i  = (c < 6);
      req_data_i = (c < 6) ? 8'(8'h10 + c) : 8'h00;
      #1;
      chk($sformatf("t3_write_c%0d", c), {31'd0, req_fifo_write_o},
          (c == 2 || c == 4 || c == 6) ? 32'd1 : 32'd0);
      chk($sformatf("t3_err_c%0d", c), {31'd0, err_o}, 32'd0);
      if (c == 2) chk("t3_din_c2", {16'd0, req_fifo_din_o}, 32'h00001110);
      if (c == 4) chk("t3_din_c4", {16'd0, req_fifo_din_o}, 32'h00001312);
      if (c == 6) chk("t3_din_c6", {16'd0, req_fifo_din_o}, 32'h00001514);
      tick();
    end
    chk("t3_idle_after", {31'd0, req_fifo_write_o}, 32'd0);

    // FIFO full for 5 cycles in S_PUSH while the core keeps offering a beat.
    req_val_i = 1'b1; req_data_i = 8'hC3; tick();
    req_data_i = 8'hD4; tick();
    req_fifo_full_i = 1'b1; req_data_i = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t4_rdy_full%0d", c), {31'd0, req_rdy_o}, 32'd0);
      chk($sformatf("t4_nowr_full%0d", c), {31'd0, req_fifo_write_o}, 32'd0);
      chk($sformatf("t4_din_full%0d", c), {16'd0, req_fifo_din_o}, 32'h0000D4C3);
      tick();
    end
    req_fifo_full_i = 1'b0; req_val_i = 1'b0; #1;
    chk("t4_write_release", {31'd0, req_fifo_write_o}, 32'd1);
    chk("t4_rdy_release", {31'd0, req_rdy_o}, 32'd1);
    chk("t4_din_release", {16'd0, req_fifo_din_o}, 32'h0000D4C3);
    tick();
    chk("t4_one_write", {31'd0, req_fifo_write_o}, 32'd0);

    // Reset in the middle of a cycle while in S_BEAT1.
    req_val_i = 1'b1; req_data_i = 8'h77; tick();
    req_val_i = 1'b0;
    #3;
    rst_ni = 1'b0;
    #1;
    chk("t1_rst_rdy", {31'd0, req_rdy_o}, 32'd1);
    chk("t1_rst_write", {31'd0, req_fifo_write_o}, 32'd0);
    chk("t1_rst_din", {16'd0, req_fifo_din_o}, 32'd0);
    chk("t1_rst_err", {31'd0, err_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t1_no_write%0d", c), {31'd0, req_fifo_write_o}, 32'd0);
      tick();
    end
    // The first beat after reset is a fresh beat0, so no write follows it.
    req_val_i = 1'b1; req_data_i = 8'h88; tick();
    req_val_i = 1'b0; #1;
    chk("t1_fresh_beat0", {31'd0, req_fifo_write_o}, 32'd0);
    req_val_i = 1'b1; req_data_i = 8'h99; tick();
    req_val_i = 1'b0; #1;
    chk("t1_fresh_write", {31'd0, req_fifo_write_o}, 32'd1);
    chk("t1_fresh_din", {16'd0, req_fifo_din_o}, 32'h00009988);
    tick();

`ifdef FALAFEL_INPUT_TIMEOUT_EN
    // beat0 then idle: 4 idle cycles count to the limit, drop on the 5th.
    req_val_i = 1'b1; req_data_i = 8'h5A; tick();
    req_val_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("t5_err_idle%0d", c), {31'd0, err_o}, 32'd0);
      tick();
    end
    chk("t5_err_pulse", {31'd0, err_o}, 32'd1);
    chk("t5_no_write", {31'd0, req_fifo_write_o}, 32'd0);
    tick();
    chk("t5_err_one_cycle", {31'd0, err_o}, 32'd0);
    req_val_i = 1'b1; req_data_i = 8'h11; tick();
    req_data_i = 8'h22; tick();
    req_val_i = 1'b0; #1;
    chk("t5_write", {31'd0, req_fifo_write_o}, 32'd1);
    chk("t5_din", {16'd0, req_fifo_din_o}, 32'h00002211);
    tick();

    // beat1 on the limit cycle is taken and err_o stays low.
    req_val_i = 1'b1; req_data_i = 8'h33; tick();
    req_val_i = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    req_val_i = 1'b1; req_data_i = 8'h44; #1;
    chk("t6_no_err", {31'd0, err_o}, 32'd0);
    tick();
    req_val_i = 1'b0; #1;
    chk("t6_write", {31'd0, req_fifo_write_o}, 32'd1);
    chk("t6_din", {16'd0, req_fifo_din_o}, 32'h00004433);
    tick();
`endif

    held = req_fifo_din_o;
    chk("end_idle", {31'd0, req_fifo_write_o}, 32'd0);
    chk("end_din_hold", {16'd0, req_fifo_din_o}, {16'd0, held});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
